// File: rtl/shift_register_universal_if.sv
// Bundles the control, data and status signals of the universal shift register.
// The master drives the controls; the slave is the register itself.
interface shift_register_universal_if #(
  parameter int WIDTH = 8
);
  localparam int CNT_W = $clog2(WIDTH + 1);

  logic             Ena;
  logic [1:0]       Mode;
  logic             LeRi;
  logic             Data_In;
  logic [WIDTH-1:0] Par_In;
  logic             Start;
  logic [CNT_W-1:0] Len;
  logic             Data_Out;
  logic [WIDTH-1:0] Par_Out;
  logic             Busy;
  logic             Done;

  modport master (
    output Ena, Mode, LeRi, Data_In, Par_In, Start, Len,
    input  Data_Out, Par_Out, Busy, Done
  );

  modport slave (
    input  Ena, Mode, LeRi, Data_In, Par_In, Start, Len,
    output Data_Out, Par_Out, Busy, Done
  );
endinterface

// File: rtl/shift_register_universal.sv
// Universal shift register: hold/shift/rotate/load in IDLE, plus an automatic
// burst of up to WIDTH shifts or rotates run by a two-state IDLE/RUN FSM.
module shift_register_universal #(
  parameter int WIDTH = 8
) (
  input logic                      Clk,
  input logic                      Rst,
  shift_register_universal_if.slave bus
);
  localparam int CNT_W = $clog2(WIDTH + 1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  localparam logic [1:0] MODE_HOLD   = 2'b00;
  localparam logic [1:0] MODE_SHIFT  = 2'b01;
  localparam logic [1:0] MODE_ROTATE = 2'b10;
  localparam logic [1:0] MODE_LOAD   = 2'b11;

  localparam logic [CNT_W-1:0] LEN_MAX = CNT_W'(WIDTH);

  logic [WIDTH-1:0] reg_q,   reg_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic [0:0]       state_q, state_d;
  logic             dir_q,   dir_d;
  logic             rot_q,   rot_d;
  logic             done_q,  done_d;

  logic [CNT_W-1:0] len_clamped;
  logic             eff_left;

  // One step in either direction; the vacated bit comes from Data_In or, when
  // rotating, from the bit falling off the opposite end.
  function automatic logic [WIDTH-1:0] step_reg(
    input logic [WIDTH-1:0] r,
    input logic             left,
    input logic             rot,
    input logic             din
  );
    logic fill;
    if (left) begin
      fill     = rot ? r[WIDTH-1] : din;
      step_reg = {r[WIDTH-2:0], fill};
    end else begin
      fill     = rot ? r[0] : din;
      step_reg = {fill, r[WIDTH-1:1]};
    end
  endfunction

  assign len_clamped = (bus.Len > LEN_MAX) ? LEN_MAX : bus.Len;

  always_comb begin
    // NOTE: every target gets a default first so no path can infer a latch.
    reg_d   = reg_q;
    cnt_d   = cnt_q;
    state_d = state_q;
    dir_d   = dir_q;
    rot_d   = rot_q;
    done_d  = 1'b0;

    if (bus.Ena) begin
      case (state_q)
        ST_IDLE: begin
          if (bus.Start) begin
            // Start wins over Mode: capture the burst setup, leave reg alone.
            dir_d = bus.LeRi;
            rot_d = (bus.Mode == MODE_ROTATE);
            cnt_d = len_clamped;
            if (len_clamped == '0) begin
              done_d = 1'b1;
            end else begin
              state_d = ST_RUN;
            end
          end else begin
            case (bus.Mode)
              MODE_HOLD:   reg_d = reg_q;
              MODE_SHIFT:  reg_d = step_reg(reg_q, bus.LeRi, 1'b0, bus.Data_In);
              MODE_ROTATE: reg_d = step_reg(reg_q, bus.LeRi, 1'b1, bus.Data_In);
              MODE_LOAD:   reg_d = bus.Par_In;
              default:     reg_d = reg_q;
            endcase
          end
        end

        ST_RUN: begin
          reg_d = step_reg(reg_q, dir_q, rot_q, bus.Data_In);
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end

        default: state_d = ST_IDLE;
      endcase
    end
  end

  // NOTE: reset clears every flop, including the data register, so outputs are
  // defined the moment Rst falls and a burst in progress is dropped silently.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      reg_q   <= '0;
      cnt_q   <= '0;
      state_q <= ST_IDLE;
      dir_q   <= 1'b0;
      rot_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      reg_q   <= reg_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
      dir_q   <= dir_d;
      rot_q   <= rot_d;
      done_q  <= done_d;
    end
  end

  // Outside a burst the live LeRi picks the serial tap; inside, the latched one.
  assign eff_left     = (state_q == ST_RUN) ? dir_q : bus.LeRi;
  assign bus.Data_Out = eff_left ? reg_q[WIDTH-1] : reg_q[0];
  assign bus.Par_Out  = reg_q;
  assign bus.Busy     = (state_q == ST_RUN);
  assign bus.Done     = done_q;

endmodule

// File: tb/tb_shift_register_universal.sv
// Self-checking bench for shift_register_universal: directed scenarios plus
// randomized traffic, all compared against an arithmetic reference model.
module tb_shift_register_universal;
  localparam int WIDTH = 8;
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam int unsigned MASK = (32'd1 << WIDTH) - 1;

  logic Clk = 1'b0;
  logic Rst;

  shift_register_universal_if #(.WIDTH(WIDTH)) bus ();

  shift_register_universal #(.WIDTH(WIDTH)) dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus.slave)
  );

  always #5 Clk = ~Clk;

  int compared   = 0;
  int mismatched = 0;

  // Reference model: register value as an integer, burst as a remaining count.
  int unsigned m_reg;
  int          m_left;
  bit          m_dir, m_rot, m_busy, m_done;

  function automatic int unsigned next_val(int unsigned r, bit left, bit rot, bit din);
    bit fill;
    if (left) begin
      fill = rot ? r[WIDTH-1] : din;
      return ((r << 1) | (fill ? 32'd1 : 32'd0)) & MASK;
    end
    fill = rot ? r[0] : din;
    return (r >> 1) | (fill ? (32'd1 << (WIDTH - 1)) : 32'd0);
  endfunction

  task automatic model_reset();
    m_reg = 0; m_left = 0; m_dir = 0; m_rot = 0; m_busy = 0; m_done = 0;
  endtask

  task automatic model_step();
    int n;
    m_done = 0;
    if (bus.Ena !== 1'b1) return;
    if (m_busy) begin
      m_reg  = next_val(m_reg, m_dir, m_rot, bus.Data_In);
      m_left = m_left - 1;
      if (m_left == 0) begin
        m_busy = 0;
        m_done = 1;
      end
    end else if (bus.Start) begin
      n      = (int'(bus.Len) > WIDTH) ? WIDTH : int'(bus.Len);
      m_dir  = bus.LeRi;
      m_rot  = (bus.Mode == 2'b10);
      if (n == 0) m_done = 1;
      else begin
        m_busy = 1;
        m_left = n;
      end
    end else begin
      case (bus.Mode)
        2'b01:   m_reg = next_val(m_reg, bus.LeRi, 1'b0, bus.Data_In);
        2'b10:   m_reg = next_val(m_reg, bus.LeRi, 1'b1, bus.Data_In);
        2'b11:   m_reg = int'(bus.Par_In);
        default: ;
      endcase
    end
  endtask

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    bit          left;
    int unsigned exp_do;
    left   = m_busy ? m_dir : bus.LeRi;
    exp_do = left ? m_reg[WIDTH-1] : m_reg[0];
    check("par_out",  32'(bus.Par_Out),  m_reg);
    check("busy",     32'(bus.Busy),     32'(m_busy));
    check("done",     32'(bus.Done),     32'(m_done));
    check("data_out", 32'(bus.Data_Out), exp_do);
  endtask

  task automatic tick();
    @(posedge Clk);
    model_step();
    @(negedge Clk);
    check_outputs();
  endtask

  task automatic drive(bit ena, logic [1:0] mode, bit leri, bit din,
                       logic [WIDTH-1:0] par, bit start, logic [CNT_W-1:0] len);
    bus.Ena = ena; bus.Mode = mode; bus.LeRi = leri; bus.Data_In = din;
    bus.Par_In = par; bus.Start = start; bus.Len = len;
    #1;
  endtask

  task automatic load(logic [WIDTH-1:0] val);
    drive(1, 2'b11, 0, 0, val, 0, '0);
    tick();
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    logic [7:0] seq;
    int busy_cnt, done_cnt;

    // Reset state.
    Rst = 1'b0;
    model_reset();
    drive(0, 2'b00, 0, 0, '0, 0, '0);
    #2;
    check("rst_par_out",  32'(bus.Par_Out),  0);
    check("rst_busy",     32'(bus.Busy),     0);
    check("rst_done",     32'(bus.Done),     0);
    check("rst_data_out", 32'(bus.Data_Out), 0);
    @(negedge Clk);
    Rst = 1'b1;

    // Load A5, then rotate left eight times back to A5.
    load(8'hA5);
    check("load_a5", 32'(bus.Par_Out), 32'h A5);
    seq = 8'b1010_0101;
    drive(1, 2'b10, 1, 0, '0, 0, '0);
    for (int i = 0; i < 8; i++) begin
      check("rot_seq_do", 32'(bus.Data_Out), 32'(seq[7-i]));
      tick();
    end
    check("rot_back_a5", 32'(bus.Par_Out), 32'hA5);

    // Right shift of ones into zero.
    load(8'h00);
    drive(1, 2'b01, 0, 1, '0, 0, '0);
    repeat (3) tick();
    check("shr_e0", 32'(bus.Par_Out), 32'hE0);

    // Len=4 left burst from 81; a Start mid-burst must be ignored.
    load(8'h81);
    drive(1, 2'b01, 1, 0, '0, 1, CNT_W'(4));
    busy_cnt = 0; done_cnt = 0;
    tick(); busy_cnt += bus.Busy; done_cnt += bus.Done;
    drive(1, 2'b00, 0, 0, '0, 1, CNT_W'(2));
    tick(); busy_cnt += bus.Busy; done_cnt += bus.Done;
    drive(1, 2'b00, 0, 0, '0, 0, '0);
    repeat (5) begin
      tick(); busy_cnt += bus.Busy; done_cnt += bus.Done;
    end
    check("b4_busy_cycles", busy_cnt, 4);
    check("b4_done_pulses", done_cnt, 1);
    check("b4_result", 32'(bus.Par_Out), 32'h10);

    // Len=3 rotate-right burst from 3C with a two-cycle Ena stall.
    load(8'h3C);
    drive(1, 2'b10, 0, 0, '0, 1, CNT_W'(3));
    busy_cnt = 0; done_cnt = 0;
    tick(); busy_cnt += bus.Busy; done_cnt += bus.Done;
    drive(1, 2'b00, 1, 1, '0, 0, '0);
    tick(); busy_cnt += bus.Busy; done_cnt += bus.Done;
    drive(0, 2'b00, 1, 1, '0, 1, CNT_W'(5));
    repeat (2) begin
      tick(); busy_cnt += bus.Busy; done_cnt += bus.Done;
    end
    drive(1, 2'b00, 1, 1, '0, 0, '0);
    repeat (4) begin
      tick(); busy_cnt += bus.Busy; done_cnt += bus.Done;
    end
    check("stall_busy_cycles", busy_cnt, 5);
    check("stall_done_pulses", done_cnt, 1);
    check("stall_result", 32'(bus.Par_Out), 32'h87);

    // Len=0 gives an immediate Done; a Start alongside that Done is taken,
    // and Len=15 is clamped to eight shifts.
    load(8'h5A);
    drive(1, 2'b01, 0, 1, '0, 1, CNT_W'(0));
    tick();
    check("len0_done", 32'(bus.Done), 1);
    check("len0_busy", 32'(bus.Busy), 0);
    check("len0_par_out", 32'(bus.Par_Out), 32'h5A);
    drive(1, 2'b01, 0, 1, '0, 1, CNT_W'(15));
    busy_cnt = 0; done_cnt = 0;
    tick(); busy_cnt += bus.Busy; done_cnt += bus.Done;
    drive(1, 2'b00, 0, 1, '0, 0, '0);
    repeat (10) begin
      tick(); busy_cnt += bus.Busy; done_cnt += bus.Done;
    end
    check("clamp_busy_cycles", busy_cnt, 8);
    check("clamp_done_pulses", done_cnt, 1);
    check("clamp_result", 32'(bus.Par_Out), 32'hFF);

    // Asynchronous reset mid-burst between clock edges.
    load(8'hC3);
    drive(1, 2'b01, 1, 1, '0, 1, CNT_W'(6));
    tick();
    drive(1, 2'b00, 1, 1, '0, 0, '0);
    repeat (2) tick();
    #2;
    Rst = 1'b0;
    #1;
    check("arst_par_out", 32'(bus.Par_Out), 0);
    check("arst_busy",    32'(bus.Busy),    0);
    check("arst_done",    32'(bus.Done),    0);
    check("arst_data_out", 32'(bus.Data_Out), 0);
    model_reset();
    @(posedge Clk);
    @(negedge Clk);
    check_outputs();
    Rst = 1'b1;
    load(8'h99);
    check("post_rst_load", 32'(bus.Par_Out), 32'h99);

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      drive($urandom_range(0, 7) != 0, 2'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            WIDTH'($urandom), $urandom_range(0, 5) == 0,
            CNT_W'($urandom_range(0, 15)));
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/shift_register_universal.md
SHIFT_REGISTER_UNIVERSAL -- requirements
Module: shift_register_universal

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the register length in bits; legal range is 2..32.
REQ-002 The block SHALL have derived parameter CNT_W, equal to clog2(WIDTH+1), giving the burst-counter width.
REQ-003 Clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 Rst  input  1  SHALL be the reset, asynchronous and active-low.
REQ-005 Ena  input  1  SHALL be the clock enable; when low, all state (register, FSM, counter) holds.
REQ-006 Mode  input  2  SHALL select the idle operation: 00 hold, 01 shift, 10 rotate, 11 parallel load.
REQ-007 LeRi  input  1  SHALL select direction: 1 = left (toward MSB), 0 = right (toward LSB).
REQ-008 Data_In  input  1  SHALL be the serial input bit.
REQ-009 Par_In  input  WIDTH  SHALL be the parallel load data.
REQ-010 Start  input  1  SHALL request an automatic burst of Len shifts.
REQ-011 Len  input  CNT_W  SHALL give the burst length; values above WIDTH SHALL be clamped to WIDTH.
REQ-012 Data_Out  output  1  SHALL be the serial output bit.
REQ-013 Par_Out  output  WIDTH  SHALL present the register contents.
REQ-014 Busy  output  1  SHALL be high while the FSM is in RUN.
REQ-015 Done  output  1  SHALL pulse high for one cycle when a burst completes.

Function
REQ-016 Left shift SHALL compute reg <= {reg[WIDTH-2:0], Data_In}.
REQ-017 Right shift SHALL compute reg <= {Data_In, reg[WIDTH-1:1]}.
REQ-018 Left rotate SHALL compute reg <= {reg[WIDTH-2:0], reg[WIDTH-1]}; right rotate SHALL compute reg <= {reg[0], reg[WIDTH-1:1]}; Data_In is ignored when rotating.
REQ-019 Data_Out SHALL be combinational: reg[WIDTH-1] when the effective direction is left, reg[0] when right.
REQ-020 Effective direction SHALL be LeRi in IDLE and the direction latched at Start while in RUN.
REQ-021 Par_Out SHALL equal reg at all times.
REQ-022 The FSM SHALL have exactly two states, IDLE and RUN.
REQ-023 In IDLE with Ena=1 and Start=0, the block SHALL apply the Mode operation with one-cycle latency.
REQ-024 In IDLE with Ena=1 and Start=1, Start SHALL take priority over Mode: the register is not modified that cycle, LeRi is latched, the rotate flag (Mode==10) is latched, and cnt is set to min(Len, WIDTH).
REQ-025 Start with a clamped length of 0 SHALL stay in IDLE and assert Done on the next cycle, with no shift.
REQ-026 Start with a clamped length of 1 or more SHALL move the FSM to RUN on the next edge.
REQ-027 In RUN with Ena=1, the block SHALL perform one shift, or one rotate if the rotate flag is latched, in the latched direction and decrement cnt; Mode, LeRi and Start are ignored.
REQ-028 In RUN with Ena=1 and cnt==1, the block SHALL perform the final shift, return to IDLE and assert Done for exactly that following cycle.
REQ-029 A burst of N SHALL occupy N Ena-high cycles in RUN; Busy SHALL be high for exactly those cycles plus any Ena-low stall cycles.
REQ-030 In RUN with Ena=0, the state, cnt, register and Busy SHALL hold; Done SHALL be low.
REQ-031 Done SHALL be low in every cycle other than the completion cycle defined in REQ-025 and REQ-028.
REQ-032 A Start arriving while Busy=1 SHALL be ignored and not queued.
REQ-033 Done and a new Start in the same cycle SHALL be legal; the new Start SHALL be accepted as in REQ-024.

Reset
REQ-034 When Rst=0, the block SHALL immediately and asynchronously clear reg, cnt, the latched direction and the rotate flag to 0, and set the FSM to IDLE.
REQ-035 While Rst=0, Par_Out SHALL be 0, Busy SHALL be 0, Done SHALL be 0, and Data_Out SHALL be 0.
REQ-036 Reset asserted mid-burst SHALL abort the burst with no Done pulse.
REQ-037 The first edge after Rst is released SHALL be processed normally.

Verification (WIDTH=8)
REQ-038 The bench SHALL cover: Mode=11, Par_In=8'hA5 -> Par_Out=8'hA5 next cycle; then Mode=10, LeRi=1 for 8 cycles -> Par_Out returns to 8'hA5, and the Data_Out sequence is 1,0,1,0,0,1,0,1.
REQ-039 The bench SHALL cover: reg=0, Mode=01, LeRi=0, Data_In=1 for 3 cycles -> Par_Out=8'hE0.
REQ-040 The bench SHALL cover: reg=8'h81, Start with Len=4, LeRi=1, Mode=01, Data_In=0 -> Busy high for 4 cycles, Done pulses once, Par_Out=8'h10.
REQ-041 The bench SHALL cover: a Len=3 burst with Ena low for 2 cycles mid-burst -> Busy high for 5 cycles, the result equals the unstalled result, and Done is a single pulse.
REQ-042 The bench SHALL cover: Start with Len=0 -> Done pulses next cycle, Busy stays 0, Par_Out unchanged; Start with Len=15 -> clamped to 8 shifts.
REQ-043 The bench SHALL cover: Rst driven low between clock edges during a Len=6 burst -> Par_Out=0 and Busy=0 immediately, with no Done pulse.
